exp_core_arbiter: RTL

- Shares one exponentiation core (modulus/Rmodm/Rsquaredmodm/exponent/x/multiplication_enable in; done/A_result out) between two requesters, round-robin.
- For each accepted job the block latches the operands, pulses the core's active-low reset, and holds start until done. It captures the result and returns it on the owner's response channel.
- A watchdog aborts a hung core.
- Sits between the Arm-facing command wrapper and the core, replacing direct per-core wiring.

---
 rtl/exp_core_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/exp_core_arbiter.sv
// exp_core_arbiter: round-robin sharing of one exponentiation core between two
// requesters. Latches the winning job's operands, pulses the core reset, holds
// start until done (or watchdog abort) and returns the result on the owner's
// response channel.
module exp_core_arbiter #(
   parameter int unsigned WIDTH      = 512,
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 1048575,
   parameter int unsigned TO_W       = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   // requester 0
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [5*WIDTH-1:0]   req0_ops,
   input  logic                 req0_mul_en,
   // requester 1
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [5*WIDTH-1:0]   req1_ops,
   input  logic                 req1_mul_en,
   // response 0
   output logic                 rsp0_valid,
   input  logic                 rsp0_ready,
   output logic [WIDTH-1:0]     rsp0_result,
   output logic                 rsp0_err,
   // response 1
   output logic                 rsp1_valid,
   input  logic                 rsp1_ready,
   output logic [WIDTH-1:0]     rsp1_result,
   output logic                 rsp1_err,
   // core side
   output logic                 core_resetn,
   output logic                 core_start,
   output logic [WIDTH-1:0]     core_modulus,
   output logic [WIDTH-1:0]     core_rmodm,
   output logic [WIDTH-1:0]     core_rsqmodm,
   output logic [WIDTH-1:0]     core_exponent,
   output logic [WIDTH-1:0]     core_x,
   output logic                 core_mul_en,
   input  logic                 core_done,
   input  logic [WIDTH-1:0]     core_result,
   // status
   output logic                 busy,
   output logic                 owner
);

   localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CORE_RST = 2'd1,
      ST_RUN      = 2'd2,
      ST_RESP     = 2'd3
   } state_t;

   state_t            state;
   logic              last_grant;
   logic [RC_W-1:0]   rst_cnt;
   logic [TO_W-1:0]   wd_cnt;

   logic              grant0_c;
   logic              grant1_c;
   logic [5*WIDTH-1:0] sel_ops_c;
   logic              timeout_hit_c;
   logic              run_finish_c;
   logic [WIDTH-1:0]  cap_result_c;
   logic              cap_err_c;
   logic              owner_rsp_ready_c;

   // Round-robin grant from valids and last_grant only; requester 0 wins ties after reset.
   always_comb begin
      grant0_c          = req0_valid && (!req1_valid || last_grant);
      grant1_c          = req1_valid && (!req0_valid || !last_grant);
      sel_ops_c         = grant1_c ? req1_ops : req0_ops;
      timeout_hit_c     = (TIMEOUT != 0) && (wd_cnt == TO_W'(TIMEOUT - 1));
      run_finish_c      = core_done || timeout_hit_c;
      cap_result_c      = core_done ? core_result : '0;
      cap_err_c         = !core_done;
      owner_rsp_ready_c = owner ? rsp1_ready : rsp0_ready;
   end

   assign req0_ready = (state == ST_IDLE) && grant0_c;
   assign req1_ready = (state == ST_IDLE) && grant1_c;
   assign busy       = (state != ST_IDLE);

   // Job sequencing FSM with all core and response outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         last_grant    <= 1'b1;
         owner         <= 1'b1;
         rst_cnt       <= '0;
         wd_cnt        <= '0;
         rsp0_valid    <= 1'b0;
         rsp0_err      <= 1'b0;
         rsp0_result   <= '0;
         rsp1_valid    <= 1'b0;
         rsp1_err      <= 1'b0;
         rsp1_result   <= '0;
         core_resetn   <= 1'b0;
         core_start    <= 1'b0;
         core_modulus  <= '0;
         core_rmodm    <= '0;
         core_rsqmodm  <= '0;
         core_exponent <= '0;
         core_x        <= '0;
         core_mul_en   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               core_resetn <= 1'b0;
               core_start  <= 1'b0;
               if (grant0_c || grant1_c) begin
                  core_modulus  <= sel_ops_c[5*WIDTH-1 -: WIDTH];
                  core_rmodm    <= sel_ops_c[4*WIDTH-1 -: WIDTH];
                  core_rsqmodm  <= sel_ops_c[3*WIDTH-1 -: WIDTH];
                  core_exponent <= sel_ops_c[2*WIDTH-1 -: WIDTH];
                  core_x        <= sel_ops_c[WIDTH-1:0];
                  core_mul_en   <= grant1_c ? req1_mul_en : req0_mul_en;
                  owner         <= grant1_c;
                  last_grant    <= grant1_c;
                  rst_cnt       <= '0;
                  state         <= ST_CORE_RST;
               end
            end
            ST_CORE_RST: begin
               if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                  core_resetn <= 1'b1;
                  core_start  <= 1'b1;
                  wd_cnt      <= '0;
                  state       <= ST_RUN;
               end else begin
                  rst_cnt <= rst_cnt + RC_W'(1);
               end
            end
            ST_RUN: begin
               wd_cnt <= wd_cnt + TO_W'(1);
               if (run_finish_c) begin
                  if (owner) begin
                     rsp1_valid  <= 1'b1;
                     rsp1_result <= cap_result_c;
                     rsp1_err    <= cap_err_c;
                  end else begin
                     rsp0_valid  <= 1'b1;
                     rsp0_result <= cap_result_c;
                     rsp0_err    <= cap_err_c;
                  end
                  core_resetn <= 1'b0;
                  core_start  <= 1'b0;
                  state       <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (owner_rsp_ready_c) begin
                  rsp0_valid  <= 1'b0;
                  rsp0_err    <= 1'b0;
                  rsp0_result <= '0;
                  rsp1_valid  <= 1'b0;
                  rsp1_err    <= 1'b0;
                  rsp1_result <= '0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
